// File: rtl/bar_sort_engine_if.sv
// ----------------------------------------------------------------------------
// bar_sort_engine_if
// Handshake/bus bundle for bar_sort_engine.
//   master : drives load, load_data, start, descending, pause;
//            observes heights, busy, done, cmp_idx, sorted_from,
//            swap_pulse, pass_cnt.
//   slave  : the sort engine side (directions mirrored).
// Parameters N_BARS and H_W must match the engine instance; IDX_W is derived
// the same way the engine derives it.
// ----------------------------------------------------------------------------
interface bar_sort_engine_if #(
    parameter int N_BARS = 8,
    parameter int H_W    = 7
);
    localparam int IDX_W = $clog2(N_BARS + 1);

    logic                    load;
    logic [N_BARS*H_W-1:0]   load_data;
    logic                    start;
    logic                    descending;
    logic                    pause;
    logic [N_BARS*H_W-1:0]   heights;
    logic                    busy;
    logic                    done;
    logic [IDX_W-1:0]        cmp_idx;
    logic [IDX_W-1:0]        sorted_from;
    logic                    swap_pulse;
    logic [IDX_W-1:0]        pass_cnt;

    modport master (
        output load, load_data, start, descending, pause,
        input  heights, busy, done, cmp_idx, sorted_from, swap_pulse, pass_cnt
    );

    modport slave (
        input  load, load_data, start, descending, pause,
        output heights, busy, done, cmp_idx, sorted_from, swap_pulse, pass_cnt
    );
endinterface

// File: rtl/bar_sort_engine.sv
// ----------------------------------------------------------------------------
// bar_sort_engine
// Visual bubble-sort engine: holds N_BARS unsigned heights and sorts them one
// compare/swap step every STEP_DIV clocks, so a display can animate the sort.
//
// Ports
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : bar_sort_engine_if.slave
//            load/load_data  - capture a new height array (IDLE/DONE only)
//            start           - begin a sort (IDLE/DONE only, load wins)
//            descending      - sort order, sampled at start
//            pause           - freeze timer, indices and heights while in RUN
//            heights         - current array, bar k at [k*H_W +: H_W]
//            busy/done       - RUN / DONE status
//            cmp_idx         - left index of the pair being compared
//            sorted_from     - bars at or above this index are final
//            swap_pulse      - one-cycle pulse per swap
//            pass_cnt        - completed passes
//
// Optional feature macro: BAR_SORT_EARLY_EXIT_EN
//   When defined, a pass that performs no swap ends the sort early.
// ----------------------------------------------------------------------------
module bar_sort_engine #(
    parameter int N_BARS   = 8,
    parameter int H_W      = 7,
    parameter int STEP_DIV = 50000000
) (
    input  logic               clk,
    input  logic               rst_n,
    bar_sort_engine_if.slave   bus
);
    localparam int IDX_W = $clog2(N_BARS + 1);
    localparam int TMR_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [TMR_W-1:0]   tmr;
    logic [IDX_W-1:0]   i_q;
    logic [IDX_W-1:0]   j_q;
    logic [IDX_W-1:0]   sorted_q;
    logic [IDX_W-1:0]   pass_q;
    logic               desc_q;
    logic               busy_q;
    logic               done_q;
    logic               swap_q;
    logic [H_W-1:0]     h [N_BARS];
`ifdef BAR_SORT_EARLY_EXIT_EN
    logic               swapped_q;
`endif

    logic [H_W-1:0]     h_lo;
    logic [H_W-1:0]     h_hi;
    logic [IDX_W-1:0]   last_j;
    logic               step;
    logic               do_swap;
    logic               pass_end;
    logic               early_done;
    logic               finish;

    // Pair under comparison, selected by j.
    always_comb begin
        h_lo = '0;
        h_hi = '0;
        for (int k = 0; k < N_BARS - 1; k++) begin
            if (j_q == IDX_W'(k)) begin
                h_lo = h[k];
                h_hi = h[k+1];
            end
        end
    end

    assign step     = (state == RUN) && !bus.pause && (tmr == TMR_LAST);
    // Strict compares keep equal heights in place (stable sort).
    assign do_swap  = desc_q ? (h_lo < h_hi) : (h_lo > h_hi);
    assign last_j   = IDX_W'(N_BARS - 2) - i_q;
    assign pass_end = (j_q == last_j);

`ifdef BAR_SORT_EARLY_EXIT_EN
    assign early_done = !(swapped_q || do_swap);
`else
    assign early_done = 1'b0;
`endif
    assign finish = (i_q == IDX_W'(N_BARS - 2)) || early_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tmr      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            sorted_q <= IDX_W'(N_BARS);
            pass_q   <= '0;
            desc_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            swap_q   <= 1'b0;
            for (int k = 0; k < N_BARS; k++) h[k] <= H_W'(k + 1);
`ifdef BAR_SORT_EARLY_EXIT_EN
            swapped_q <= 1'b0;
`endif
        end else begin
            swap_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.load) begin
                        for (int k = 0; k < N_BARS; k++)
                            h[k] <= bus.load_data[k*H_W +: H_W];
                        pass_q   <= '0;
                        sorted_q <= IDX_W'(N_BARS);
                        done_q   <= 1'b0;
                        state    <= IDLE;
                    end else if (bus.start) begin
                        state    <= RUN;
                        tmr      <= '0;
                        i_q      <= '0;
                        j_q      <= '0;
                        sorted_q <= IDX_W'(N_BARS);
                        pass_q   <= '0;
                        desc_q   <= bus.descending;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
`ifdef BAR_SORT_EARLY_EXIT_EN
                        swapped_q <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (!bus.pause) begin
                        tmr <= (tmr == TMR_LAST) ? '0 : tmr + TMR_W'(1);
                        if (step) begin
                            if (do_swap) begin
                                for (int k = 0; k < N_BARS - 1; k++) begin
                                    if (j_q == IDX_W'(k)) begin
                                        h[k]   <= h_hi;
                                        h[k+1] <= h_lo;
                                    end
                                end
                                swap_q <= 1'b1;
                            end
`ifdef BAR_SORT_EARLY_EXIT_EN
                            swapped_q <= swapped_q | do_swap;
`endif
                            if (pass_end) begin
                                pass_q <= pass_q + IDX_W'(1);
                                if (finish) begin
                                    state    <= DONE;
                                    sorted_q <= '0;
                                    busy_q   <= 1'b0;
                                    done_q   <= 1'b1;
                                end else begin
                                    sorted_q <= IDX_W'(N_BARS - 1) - i_q;
                                    i_q      <= i_q + IDX_W'(1);
                                    j_q      <= '0;
`ifdef BAR_SORT_EARLY_EXIT_EN
                                    swapped_q <= 1'b0;
`endif
                                end
                            end else begin
                                j_q <= j_q + IDX_W'(1);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_BARS; g++) begin : g_pack
            assign bus.heights[g*H_W +: H_W] = h[g];
        end
    endgenerate

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cmp_idx     = j_q;
    assign bus.sorted_from = sorted_q;
    assign bus.swap_pulse  = swap_q;
    assign bus.pass_cnt    = pass_q;
endmodule
